// File: rtl/noc_local_injector_if.sv
// Tile-side request/body/flit/credit bundle between a tile, its network interface and the router local port.
// The slave modport is the injector's view.
interface noc_local_injector_if #(
  parameter int FlitSize = 64,
  parameter int MaxBody  = 8,
  parameter int Credits  = 4
);
  localparam int XyWidth   = 6;
  localparam int MsgWidth  = 5;
  localparam int LenWidth  = $clog2(MaxBody + 1);
  localparam int CredWidth = $clog2(Credits + 1);

  logic                  req_valid;
  logic                  req_ready;
  logic [XyWidth-1:0]    req_dst;
  logic [MsgWidth-1:0]   req_msg;
  logic [LenWidth-1:0]   req_len;
  logic                  data_valid;
  logic                  data_ready;
  logic [FlitSize-3:0]   data;
  logic                  flit_valid;
  logic [FlitSize-1:0]   flit_out;
  logic                  credit_in;
  logic [CredWidth-1:0]  credits_avail;
  logic                  credit_err;

  modport master (
    output req_valid, req_dst, req_msg, req_len, data_valid, data, credit_in,
    input  req_ready, data_ready, flit_valid, flit_out, credits_avail, credit_err
  );

  modport slave (
    input  req_valid, req_dst, req_msg, req_len, data_valid, data, credit_in,
    output req_ready, data_ready, flit_valid, flit_out, credits_avail, credit_err
  );
endinterface

// File: rtl/noc_local_injector.sv
// Ring NoC network-interface transmitter: turns tile requests into head/body flits
// and injects them into the router local port under credit-based flow control.
module noc_local_injector #(
  parameter int FlitSize = 64,
  parameter int MaxBody  = 8,
  parameter int Credits  = 4,
  localparam int XyWidth = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XyWidth-1:0] position,
  noc_local_injector_if.slave bus
);
  localparam int MsgWidth  = 5;
  localparam int LenWidth  = $clog2(MaxBody + 1);
  localparam int CredWidth = $clog2(Credits + 1);
  localparam int HeadPad   = FlitSize - 2 - 2 * XyWidth - MsgWidth;

  localparam logic [LenWidth-1:0]  MaxLen  = LenWidth'(MaxBody);
  localparam logic [LenWidth-1:0]  LenOne  = LenWidth'(1);
  localparam logic [CredWidth-1:0] CredMax = CredWidth'(Credits);
  localparam logic [CredWidth-1:0] CredOne = CredWidth'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_BODY
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [XyWidth-1:0]   r_dst;
  logic [MsgWidth-1:0]  r_msg;
  logic [LenWidth-1:0]  r_len;
  logic [LenWidth-1:0]  r_rem;
  logic [LenWidth-1:0]  w_rem_next;
  logic [CredWidth-1:0] r_credits;
  logic                 r_credit_err;
  logic                 r_flit_valid;
  logic [FlitSize-1:0]  r_flit;
  logic                 w_flit_valid_next;
  logic [FlitSize-1:0]  w_flit_next;
  logic                 w_send;
  logic                 w_has_credit;
  logic                 w_accept;
  logic [LenWidth-1:0]  w_len_clamped;
  logic [FlitSize-1:0]  w_head_flit;
  logic [FlitSize-1:0]  w_body_flit;

  assign w_has_credit = (r_credits != '0);

  // rst gates ready so the tile never sees an accept while the block is held in reset
  assign bus.req_ready  = (r_state == ST_IDLE) && rst;
  assign bus.data_ready = (r_state == ST_BODY) && bus.data_valid && w_has_credit;
  assign w_accept       = bus.req_valid && bus.req_ready;

  assign w_len_clamped = (bus.req_len > MaxLen) ? MaxLen : bus.req_len;

  assign w_head_flit = {1'b1, (r_len == '0), position, r_dst, r_msg, {HeadPad{1'b0}}};
  assign w_body_flit = {1'b0, (r_rem == LenOne), bus.data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_flit_valid_next = 1'b0;
    w_flit_next       = r_flit;
    w_rem_next        = r_rem;
    w_send            = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (w_has_credit) begin
          w_send            = 1'b1;
          w_flit_valid_next = 1'b1;
          w_flit_next       = w_head_flit;
          w_rem_next        = r_len;
          w_state_next      = (r_len == '0) ? ST_IDLE : ST_BODY;
        end
      end
      ST_BODY: begin
        if (bus.data_ready) begin
          w_send            = 1'b1;
          w_flit_valid_next = 1'b1;
          w_flit_next       = w_body_flit;
          w_rem_next        = r_rem - LenOne;
          if (r_rem == LenOne) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dst <= '0;
      r_msg <= '0;
      r_len <= '0;
    end else if (w_accept) begin
      r_dst <= bus.req_dst;
      r_msg <= bus.req_msg;
      r_len <= w_len_clamped;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flit_valid <= 1'b0;
      r_flit       <= '0;
      r_rem        <= '0;
    end else begin
      r_flit_valid <= w_flit_valid_next;
      r_flit       <= w_flit_next;
      r_rem        <= w_rem_next;
    end
  end

  // A returned credit and a sent flit in the same cycle cancel out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credits    <= CredMax;
      r_credit_err <= 1'b0;
    end else begin
      if (w_send && !bus.credit_in) begin
        r_credits <= r_credits - CredOne;
      end else if (!w_send && bus.credit_in) begin
        if (r_credits == CredMax) begin
          r_credit_err <= 1'b1;
        end else begin
          r_credits <= r_credits + CredOne;
        end
      end
    end
  end

  assign bus.flit_valid    = r_flit_valid;
  assign bus.flit_out      = r_flit;
  assign bus.credits_avail = r_credits;
  assign bus.credit_err    = r_credit_err;
endmodule

// File: doc/noc_local_injector.md
Name: noc_local_injector

Overview:
- Network-interface transmitter that builds ring NoC packets from tile requests and injects them into the router's local input port.
- Uses credit-based flow control (kFlowControlCreditBased): one credit per free slot in the router's local input FIFO, with credits returned by the router.
- Produces a head flit carrying source and destination coordinates plus the message type, followed by 0..MaxBody body flits, with the head/tail preamble set on each flit.

Parameters:
- FlitSize, 64, flit width in bits. Must be ≥ 2+2*(xWidth+yWidth)+messageTypeWidth.
- MaxBody, 8, maximum body flits per packet.
- Credits, 4, router local input FIFO depth; this is the credit counter reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- position  in  xWidth+yWidth (6)  local tile xy_t, treated as static.
- req_valid  in  1  packet request valid.
- req_ready  out  1  request accepted when high together with req_valid.
- req_dst  in  6  destination xy_t.
- req_msg  in  messageTypeWidth (5)  message_t.
- req_len  in  $clog2(MaxBody+1) (4)  number of body flits.
- data_valid  in  1  body word valid.
- data_ready  out  1  body word consumed this cycle.
- data  in  FlitSize-2  body payload.
- flit_valid  out  1  flit_out valid; exactly one flit per high cycle.
- flit_out  out  FlitSize  flit to router local port.
- credit_in  in  1  single-cycle pulse; returns one credit.
- credits_avail  out  $clog2(Credits+1)  current credit count.
- credit_err  out  1  sticky overflow flag.

Behaviour:
- **Reset** (rst low, async):
  - State IDLE.
  - flit_valid=0, flit_out=0, credits_avail=Credits, credit_err=0, req_ready=0 during reset, data_ready=0.
- **Flit formats** (bit positions shown for FlitSize=64):
  - Head flit: [63]=head=1, [62]=tail=(len==0), [61:56]=position {y,x}, [55:50]=req_dst {y,x}, [49:45]=req_msg, remaining bits 0.
  - Body flit: [63]=0, [62]=tail (1 on the last body flit only), [61:0]=data.
- **FSM states: IDLE, HEAD, BODY.**
- **IDLE:**
  - req_ready=1.
  - On req_valid at the edge, latch dst, msg and len, then go to HEAD.
- **HEAD:**
  - req_ready=0.
  - If credits_avail>0, at the next edge: flit_valid←1, flit_out←head flit, credit consumed.
  - Next state is IDLE if len==0, otherwise BODY with the remaining-body counter set to len.
  - With 0 credits, stay in HEAD with flit_valid←0.
- **BODY:**
  - data_ready = data_valid && credits_avail>0 (combinational).
  - On data_ready at the edge: flit_valid←1, flit_out←body flit, remaining count decremented, credit consumed.
  - When the count reaches 0, tail=1 and state→IDLE.
  - In any other cycle flit_valid←0.
- **Latency and throughput:**
  - Head flit_valid is high in the cycle after the edge following request acceptance (2 cycles after the accept cycle).
  - Body flits can be emitted back-to-back, one per cycle.
  - At least one IDLE cycle separates packets.
- **Credit counter:**
  - Flit sent only → -1.
  - credit_in only → +1.
  - Both in the same cycle → unchanged.
  - Never goes below 0, because emission is gated on credits_avail>0.
  - credit_in arriving while count==Credits with no flit sent → count held at Credits and credit_err←1. credit_err stays set until reset.
- **Other rules:**
  - req_len > MaxBody is treated as MaxBody.
  - Reset mid-packet aborts the packet; no tail is emitted, and credits restore to Credits.
  - data_valid outside BODY is ignored (data_ready=0).

Test Plan:
1. **Single-flit packet:** position=(x2,y1), dst=(x5,y3), msg=5'h0A, len=0 → one flit with [63:62]=2'b11, [61:56]=6'b001010, [55:50]=6'b011101, [49:45]=5'h0A; credits_avail 4→3; state returns to IDLE.
2. **Back-to-back body:** len=3, data_valid held high with data 1,2,3 → 4 consecutive flit_valid cycles, preambles 10,00,00,01, payloads 1,2,3; credits_avail 4→0.
3. **Credit stall:** Credits=4, len=6, no credit_in → exactly 4 flits, then flit_valid=0 and data_ready=0. One credit_in pulse → exactly one further flit.
4. **Simultaneous flit and credit:** with credits_avail=2, send a body flit in the same cycle as credit_in → credits_avail stays 2.
5. **Credit overflow:** after reset, pulse credit_in → credit_err=1, credits_avail=4. credit_err stays set through a later full packet.
6. **Reset mid-packet:** assert rst after the 2nd body flit of a len=5 packet → flit_valid=0 immediately, credits_avail=4. After rst deasserts, req_ready=1 and a new len=0 packet emits a head+tail flit.
